// File: rtl/alu_rs_age_if.sv
`default_nettype none
//==============================================================================
// Module   : alu_rs_age_if
// Brief    : Dispatcher / writeback / branch / issue bundle for the ALU RS.
// Revision : 1.0
//==============================================================================
interface alu_rs_age_if #(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 2,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int BTAG_W = 4
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_BN_W  = $clog2(BTAG_W);

    logic                     rdy;
    logic [NUM_WB-1:0]        wb_en;
    logic [NUM_WB*TAG_W-1:0]  wb_tag;
    logic [NUM_WB*DATA_W-1:0] wb_data;
    logic                     alloc_en;
    logic [OP_W-1:0]          alloc_op;
    logic [DATA_W-1:0]        alloc_pc;
    logic [TAG_W-1:0]         alloc_tag_w;
    logic [TAG_W-1:0]         alloc_tag_o;
    logic [TAG_W-1:0]         alloc_tag_t;
    logic [DATA_W-1:0]        alloc_data_o;
    logic [DATA_W-1:0]        alloc_data_t;
    logic [BTAG_W-1:0]        alloc_btag;
    logic                     alloc_ready;
    logic [c_CNT_W-1:0]       free_cnt;
    logic                     issue_valid;
    logic [OP_W-1:0]          issue_op;
    logic [DATA_W-1:0]        issue_a;
    logic [DATA_W-1:0]        issue_b;
    logic [DATA_W-1:0]        issue_pc;
    logic [TAG_W-1:0]         issue_tag_w;
    logic [BTAG_W-1:0]        issue_btag;
    logic                     br_free_en;
    logic [c_BN_W-1:0]        br_free_num;
    logic                     mis_taken;

    modport master (
        output rdy, wb_en, wb_tag, wb_data,
        output alloc_en, alloc_op, alloc_pc, alloc_tag_w, alloc_tag_o, alloc_tag_t,
        output alloc_data_o, alloc_data_t, alloc_btag,
        output br_free_en, br_free_num, mis_taken,
        input  alloc_ready, free_cnt,
        input  issue_valid, issue_op, issue_a, issue_b, issue_pc, issue_tag_w, issue_btag
    );

    modport slave (
        input  rdy, wb_en, wb_tag, wb_data,
        input  alloc_en, alloc_op, alloc_pc, alloc_tag_w, alloc_tag_o, alloc_tag_t,
        input  alloc_data_o, alloc_data_t, alloc_btag,
        input  br_free_en, br_free_num, mis_taken,
        output alloc_ready, free_cnt,
        output issue_valid, issue_op, issue_a, issue_b, issue_pc, issue_tag_w, issue_btag
    );
endinterface
`default_nettype wire

// File: rtl/alu_rs_age.sv
`default_nettype none
//==============================================================================
// Module   : alu_rs_age
// Brief    : ALU reservation station with writeback snooping, oldest-ready
//            issue via an age matrix, and branch-mask kill on mispredict.
// Revision : 1.0
//==============================================================================
module alu_rs_age #(
    parameter int              DEPTH    = 8,
    parameter int              NUM_WB   = 2,
    parameter int              DATA_W   = 32,
    parameter int              TAG_W    = 4,
    parameter logic [TAG_W-1:0] TAG_FREE = '0,
    parameter int              OP_W     = 6,
    parameter int              BTAG_W   = 4
) (
    input logic         clk,
    input logic         rst,
    alu_rs_age_if.slave bus
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    // Entry storage
    logic [DEPTH-1:0]  r_valid;
    logic [OP_W-1:0]   r_op     [DEPTH];
    logic [DATA_W-1:0] r_pc     [DEPTH];
    logic [TAG_W-1:0]  r_tag_w  [DEPTH];
    logic [TAG_W-1:0]  r_tag_o  [DEPTH];
    logic [TAG_W-1:0]  r_tag_t  [DEPTH];
    logic [DATA_W-1:0] r_data_o [DEPTH];
    logic [DATA_W-1:0] r_data_t [DEPTH];
    logic [BTAG_W-1:0] r_btag   [DEPTH];
    // r_age[i][j] = 1 : entry i is younger than entry j
    logic [DEPTH-1:0]  r_age    [DEPTH];

    logic              r_iss_valid;
    logic [OP_W-1:0]   r_iss_op;
    logic [DATA_W-1:0] r_iss_a;
    logic [DATA_W-1:0] r_iss_b;
    logic [DATA_W-1:0] r_iss_pc;
    logic [TAG_W-1:0]  r_iss_tag_w;
    logic [BTAG_W-1:0] r_iss_btag;

    logic [TAG_W-1:0]  w_tag_o_nx  [DEPTH];
    logic [TAG_W-1:0]  w_tag_t_nx  [DEPTH];
    logic [DATA_W-1:0] w_data_o_nx [DEPTH];
    logic [DATA_W-1:0] w_data_t_nx [DEPTH];
    logic [DEPTH-1:0]  w_kill;
    logic [DEPTH-1:0]  w_ready;
    logic [DEPTH-1:0]  w_sel;
    logic [DEPTH-1:0]  w_alloc_oh;
    logic              w_alloc_ready;
    logic              w_alloc_fire;
    logic              w_mis;
    logic [BTAG_W-1:0] w_clr_mask;
    logic [TAG_W-1:0]  w_alloc_tag_o;
    logic [TAG_W-1:0]  w_alloc_tag_t;
    logic [DATA_W-1:0] w_alloc_data_o;
    logic [DATA_W-1:0] w_alloc_data_t;
    logic [c_CNT_W-1:0] w_free_cnt;
    logic [OP_W-1:0]   w_iss_op;
    logic [DATA_W-1:0] w_iss_a;
    logic [DATA_W-1:0] w_iss_b;
    logic [DATA_W-1:0] w_iss_pc;
    logic [TAG_W-1:0]  w_iss_tag_w;
    logic [BTAG_W-1:0] w_iss_btag;

    // Snoop all writeback ports; iterating downwards lets the lowest port win.
    function automatic logic [TAG_W+DATA_W-1:0] f_wake(
        input logic [TAG_W-1:0]         tag,
        input logic [DATA_W-1:0]        data,
        input logic [NUM_WB-1:0]        en,
        input logic [NUM_WB*TAG_W-1:0]  tags,
        input logic [NUM_WB*DATA_W-1:0] datas
    );
        logic [TAG_W+DATA_W-1:0] res;
        res = {tag, data};
        if (tag != TAG_FREE) begin
            for (int k = NUM_WB - 1; k >= 0; k--) begin
                if (en[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
                    res = {TAG_FREE, datas[k*DATA_W +: DATA_W]};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        w_mis      = bus.br_free_en & bus.mis_taken;
        w_clr_mask = '1;
        if (bus.br_free_en && !bus.mis_taken) begin
            w_clr_mask[bus.br_free_num] = 1'b0;
        end
    end

    always_comb begin
        w_kill  = '0;
        w_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            {w_tag_o_nx[i], w_data_o_nx[i]} = f_wake(r_tag_o[i], r_data_o[i],
                                                     bus.wb_en, bus.wb_tag, bus.wb_data);
            {w_tag_t_nx[i], w_data_t_nx[i]} = f_wake(r_tag_t[i], r_data_t[i],
                                                     bus.wb_en, bus.wb_tag, bus.wb_data);
            w_kill[i]  = r_valid[i] & w_mis & r_btag[i][bus.br_free_num];
            w_ready[i] = r_valid[i] & ~w_kill[i] &
                         (w_tag_o_nx[i] == TAG_FREE) & (w_tag_t_nx[i] == TAG_FREE);
        end
    end

    // Oldest ready: no other ready entry is older than it.
    always_comb begin
        w_sel       = '0;
        w_iss_op    = '0;
        w_iss_a     = '0;
        w_iss_b     = '0;
        w_iss_pc    = '0;
        w_iss_tag_w = TAG_FREE;
        w_iss_btag  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_sel[i] = w_ready[i] & ~|(w_ready & r_age[i]);
            if (w_sel[i]) begin
                w_iss_op    = r_op[i];
                w_iss_a     = w_data_o_nx[i];
                w_iss_b     = w_data_t_nx[i];
                w_iss_pc    = r_pc[i];
                w_iss_tag_w = r_tag_w[i];
                w_iss_btag  = r_btag[i] & w_clr_mask;
            end
        end
    end

    // Alloc targets the lowest empty slot of the current state; same-cycle frees
    // are not reused until the next cycle. Alloc while full is silently dropped.
    always_comb begin
        w_alloc_oh    = ~r_valid & (r_valid + DEPTH'(1));
        w_alloc_ready = ~&r_valid;
        w_alloc_fire  = bus.alloc_en & w_alloc_ready &
                        ~(w_mis & bus.alloc_btag[bus.br_free_num]);
        {w_alloc_tag_o, w_alloc_data_o} = f_wake(bus.alloc_tag_o, bus.alloc_data_o,
                                                 bus.wb_en, bus.wb_tag, bus.wb_data);
        {w_alloc_tag_t, w_alloc_data_t} = f_wake(bus.alloc_tag_t, bus.alloc_data_t,
                                                 bus.wb_en, bus.wb_tag, bus.wb_data);
    end

    assign w_free_cnt = c_CNT_W'(DEPTH) - c_CNT_W'($countones(r_valid));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= '0;
            r_iss_valid <= 1'b0;
            r_iss_op    <= '0;
            r_iss_a     <= '0;
            r_iss_b     <= '0;
            r_iss_pc    <= '0;
            r_iss_tag_w <= TAG_FREE;
            r_iss_btag  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]     <= '0;
                r_pc[i]     <= '0;
                r_tag_w[i]  <= TAG_FREE;
                r_tag_o[i]  <= TAG_FREE;
                r_tag_t[i]  <= TAG_FREE;
                r_data_o[i] <= '0;
                r_data_t[i] <= '0;
                r_btag[i]   <= '0;
                r_age[i]    <= '0;
            end
        end else if (bus.rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_fire && w_alloc_oh[i]) begin
                    r_valid[i]  <= 1'b1;
                    r_op[i]     <= bus.alloc_op;
                    r_pc[i]     <= bus.alloc_pc;
                    r_tag_w[i]  <= bus.alloc_tag_w;
                    r_tag_o[i]  <= w_alloc_tag_o;
                    r_tag_t[i]  <= w_alloc_tag_t;
                    r_data_o[i] <= w_alloc_data_o;
                    r_data_t[i] <= w_alloc_data_t;
                    r_btag[i]   <= bus.alloc_btag & w_clr_mask;
                    r_age[i]    <= ~w_alloc_oh;
                end else begin
                    if (w_sel[i] || w_kill[i]) begin
                        r_valid[i] <= 1'b0;
                    end
                    r_tag_o[i]  <= w_tag_o_nx[i];
                    r_tag_t[i]  <= w_tag_t_nx[i];
                    r_data_o[i] <= w_data_o_nx[i];
                    r_data_t[i] <= w_data_t_nx[i];
                    r_btag[i]   <= r_btag[i] & w_clr_mask;
                    if (w_alloc_fire) begin
                        r_age[i] <= r_age[i] & ~w_alloc_oh;
                    end
                end
            end
            r_iss_valid <= |w_sel;
            r_iss_op    <= w_iss_op;
            r_iss_a     <= w_iss_a;
            r_iss_b     <= w_iss_b;
            r_iss_pc    <= w_iss_pc;
            r_iss_tag_w <= w_iss_tag_w;
            r_iss_btag  <= w_iss_btag;
        end
    end

    assign bus.alloc_ready = w_alloc_ready;
    assign bus.free_cnt    = w_free_cnt;
    assign bus.issue_valid = r_iss_valid;
    assign bus.issue_op    = r_iss_op;
    assign bus.issue_a     = r_iss_a;
    assign bus.issue_b     = r_iss_b;
    assign bus.issue_pc    = r_iss_pc;
    assign bus.issue_tag_w = r_iss_tag_w;
    assign bus.issue_btag  = r_iss_btag;

endmodule
`default_nettype wire
